// File: rtl/bit_entry_ctrl.sv
// Button front-end: two-flop sync, debounce, press detection, arbitration and a bit FIFO
// feeding the sequence detector, with a post-match lockout window.
module bit_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FIFO_DEPTH      = 4,
    parameter int LOCK_CYCLES     = 50000000
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ONE,
    input  logic                          ZERO,
    input  logic                          CLEAR,
    input  logic                          MATCH,
    output logic                          BIT_VALID,
    output logic                          BIT_DATA,
    input  logic                          BIT_READY,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          COLLISION,
    output logic                          OVERFLOW,
    output logic                          LOCKED
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Button vectors: index 0 = ZERO, index 1 = ONE
    logic [1:0]     meta_r;
    logic [1:0]     sync_r;
    logic [1:0]     deb_r;
    logic [1:0]     deb_d_r;
    logic [DCW-1:0] deb_cnt_r [2];

    state_t         state_r;
    logic [LCW-1:0] lock_cnt_r;
    logic           mem_r [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           valid_r;
    logic           data_r;
    logic           collision_r;
    logic           overflow_r;
    logic           locked_r;

    logic           zero_press_s;
    logic           one_press_s;
    logic           ev_valid_s;
    logic           ev_bit_s;
    logic           run_s;
    logic           full_s;
    logic           pop_s;
    logic           push_s;
    logic           drop_s;
    logic           coll_s;
    logic [PW-1:0]  next_rd_s;
    logic [CW-1:0]  count_nxt_s;
    logic           head_s;

    // Two-flop synchroniser for the raw asynchronous buttons
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta_r <= 2'b00;
            sync_r <= 2'b00;
        end else begin
            meta_r <= {ONE, ZERO};
            sync_r <= meta_r;
        end
    end

    // Per-button debounce counter; the level flips after DEBOUNCE_CYCLES differing samples
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            deb_r   <= 2'b00;
            deb_d_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_r[i] <= '0;
            end
        end else begin
            deb_d_r <= deb_r;
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    deb_r[i]     <= ~deb_r[i];
                    deb_cnt_r[i] <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DCW'(1'b1);
                end
            end
        end
    end

    // Event arbitration and FIFO next-state computation
    always_comb begin
        zero_press_s = deb_r[0] & ~deb_d_r[0];
        one_press_s  = deb_r[1] & ~deb_d_r[1];
        ev_valid_s   = zero_press_s | one_press_s;
        ev_bit_s     = ~zero_press_s;
        run_s        = (state_r == ST_RUN) && !CLEAR && !MATCH;
        full_s       = (count_r == FULL_CNT);
        pop_s        = BIT_READY && (count_r != '0);
        push_s       = run_s && ev_valid_s && (!full_s || pop_s);
        drop_s       = run_s && ev_valid_s && full_s && !pop_s;
        coll_s       = run_s && zero_press_s && one_press_s;
        next_rd_s    = pop_s ? (rd_ptr_r + PW'(1'b1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
        // A bit written this cycle into the new head slot bypasses the array
        if (push_s && (wr_ptr_r == next_rd_s)) begin
            head_s = ev_bit_s;
        end else begin
            head_s = mem_r[next_rd_s];
        end
    end

    // RUN/LOCK state machine with FIFO storage and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r     <= ST_RUN;
            lock_cnt_r  <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            valid_r     <= 1'b0;
            data_r      <= 1'b0;
            collision_r <= 1'b0;
            overflow_r  <= 1'b0;
            locked_r    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 1'b0;
            end
        end else if (CLEAR) begin
            state_r     <= ST_RUN;
            lock_cnt_r  <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            valid_r     <= 1'b0;
            collision_r <= 1'b0;
            overflow_r  <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (MATCH) begin
                        state_r     <= ST_LOCK;
                        lock_cnt_r  <= '0;
                        wr_ptr_r    <= '0;
                        rd_ptr_r    <= '0;
                        count_r     <= '0;
                        valid_r     <= 1'b0;
                        collision_r <= 1'b0;
                        overflow_r  <= 1'b0;
                        locked_r    <= 1'b1;
                    end else begin
                        if (push_s) begin
                            mem_r[wr_ptr_r] <= ev_bit_s;
                            wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
                        end
                        rd_ptr_r    <= next_rd_s;
                        count_r     <= count_nxt_s;
                        valid_r     <= (count_nxt_s != '0);
                        data_r      <= (count_nxt_s != '0) ? head_s : data_r;
                        collision_r <= coll_s;
                        overflow_r  <= drop_s;
                        locked_r    <= 1'b0;
                    end
                end
                ST_LOCK: begin
                    collision_r <= 1'b0;
                    overflow_r  <= 1'b0;
                    if (MATCH) begin
                        lock_cnt_r <= '0;
                        locked_r   <= 1'b1;
                    end else if (lock_cnt_r == LOCK_LAST) begin
                        state_r    <= ST_RUN;
                        lock_cnt_r <= '0;
                        locked_r   <= 1'b0;
                    end else begin
                        lock_cnt_r <= lock_cnt_r + LCW'(1'b1);
                        locked_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_RUN;
                    lock_cnt_r  <= '0;
                    wr_ptr_r    <= '0;
                    rd_ptr_r    <= '0;
                    count_r     <= '0;
                    valid_r     <= 1'b0;
                    collision_r <= 1'b0;
                    overflow_r  <= 1'b0;
                    locked_r    <= 1'b0;
                end
            endcase
        end
    end

    assign BIT_VALID = valid_r;
    assign BIT_DATA  = data_r;
    assign COUNT     = count_r;
    assign COLLISION = collision_r;
    assign OVERFLOW  = overflow_r;
    assign LOCKED    = locked_r;

endmodule

// File: tb/tb_bit_entry_ctrl.sv
// Directed self-checking bench for bit_entry_ctrl (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, LOCK_CYCLES=8).
module tb_bit_entry_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       ONE = 1'b0;
    logic       ZERO = 1'b0;
    logic       CLEAR = 1'b0;
    logic       MATCH = 1'b0;
    logic       BIT_READY = 1'b0;
    logic       BIT_VALID;
    logic       BIT_DATA;
    logic [2:0] COUNT;
    logic       COLLISION;
    logic       OVERFLOW;
    logic       LOCKED;

    int checks = 0;
    int failures = 0;
    int coll_cnt = 0;
    int ovf_cnt = 0;

    bit_entry_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4),
        .LOCK_CYCLES    (8)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ONE      (ONE),
        .ZERO     (ZERO),
        .CLEAR    (CLEAR),
        .MATCH    (MATCH),
        .BIT_VALID(BIT_VALID),
        .BIT_DATA (BIT_DATA),
        .BIT_READY(BIT_READY),
        .COUNT    (COUNT),
        .COLLISION(COLLISION),
        .OVERFLOW (OVERFLOW),
        .LOCKED   (LOCKED)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge, pulse flags tallied
    task automatic tick();
        @(posedge CLK);
        #1;
        if (COLLISION === 1'b1) coll_cnt++;
        if (OVERFLOW === 1'b1) ovf_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input bit is_one);
        if (is_one) ONE = 1'b1; else ZERO = 1'b1;
        ticks(8);
        ONE = 1'b0;
        ZERO = 1'b0;
        ticks(8);
    endtask

    task automatic drain_expect(input string tag, input int n, input logic [3:0] bits);
        BIT_READY = 1'b1;
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_valid%0d", tag, i), BIT_VALID, 1);
            check_eq($sformatf("%s_data%0d", tag, i), BIT_DATA, bits[i]);
            tick();
        end
        BIT_READY = 1'b0;
        check_eq({tag, "_count0"}, COUNT, 0);
        check_eq({tag, "_valid_low"}, BIT_VALID, 0);
    endtask

    initial begin
        ticks(3);
        check_eq("rst_valid", BIT_VALID, 0);
        check_eq("rst_count", COUNT, 0);
        check_eq("rst_locked", LOCKED, 0);
        check_eq("rst_coll", COLLISION, 0);
        check_eq("rst_ovf", OVERFLOW, 0);
        RESET = 1'b0;
        ticks(2);

        // 1: single ZERO press, then a 2-cycle ONE glitch
        ZERO = 1'b1;
        ticks(10);
        ZERO = 1'b0;
        ticks(10);
        check_eq("t1_count", COUNT, 1);
        check_eq("t1_valid", BIT_VALID, 1);
        check_eq("t1_data", BIT_DATA, 0);
        ONE = 1'b1;
        ticks(2);
        ONE = 1'b0;
        ticks(10);
        check_eq("t1_glitch_count", COUNT, 1);
        drain_expect("t1_drain", 1, 4'b0000);

        // 2: simultaneous presses, ZERO wins
        coll_cnt = 0;
        ovf_cnt = 0;
        ONE = 1'b1;
        ZERO = 1'b1;
        ticks(10);
        ONE = 1'b0;
        ZERO = 1'b0;
        ticks(10);
        check_eq("t2_count", COUNT, 1);
        check_eq("t2_data", BIT_DATA, 0);
        check_eq("t2_coll", coll_cnt, 1);
        check_eq("t2_ovf", ovf_cnt, 0);
        drain_expect("t2_drain", 1, 4'b0000);

        // 3: five ONE presses into a 4-deep queue
        coll_cnt = 0;
        ovf_cnt = 0;
        for (int i = 0; i < 4; i++) press(1'b1);
        check_eq("t3_count4", COUNT, 4);
        check_eq("t3_no_ovf", ovf_cnt, 0);
        press(1'b1);
        check_eq("t3_count_full", COUNT, 4);
        check_eq("t3_ovf", ovf_cnt, 1);
        check_eq("t3_coll", coll_cnt, 0);
        drain_expect("t3_drain", 4, 4'b1111);

        // 4: push on full with a same-cycle pop; queue order 0,1,0,1 -> 1,0,1,1
        ovf_cnt = 0;
        press(1'b0);
        press(1'b1);
        press(1'b0);
        press(1'b1);
        check_eq("t4_full", COUNT, 4);
        ONE = 1'b1;
        ticks(6);
        BIT_READY = 1'b1;
        tick();
        BIT_READY = 1'b0;
        check_eq("t4_count", COUNT, 4);
        ONE = 1'b0;
        ticks(8);
        check_eq("t4_ovf", ovf_cnt, 0);
        drain_expect("t4_drain", 4, 4'b1101);

        // 5: MATCH flushes and locks for 8 cycles
        press(1'b0);
        press(1'b0);
        check_eq("t5_count2", COUNT, 2);
        MATCH = 1'b1;
        tick();
        MATCH = 1'b0;
        check_eq("t5_locked", LOCKED, 1);
        check_eq("t5_flush_count", COUNT, 0);
        check_eq("t5_flush_valid", BIT_VALID, 0);
        ONE = 1'b1;
        ticks(6);
        check_eq("t5_lock_count", COUNT, 0);
        tick();
        check_eq("t5_locked_7", LOCKED, 1);
        ONE = 1'b0;
        tick();
        check_eq("t5_unlocked", LOCKED, 0);
        ticks(8);
        check_eq("t5_ignored", COUNT, 0);
        press(1'b1);
        check_eq("t5_after_count", COUNT, 1);
        check_eq("t5_after_data", BIT_DATA, 1);
        drain_expect("t5_drain", 1, 4'b0001);

        // 6: async reset with COUNT=3, async reset mid-lock, CLEAR in lock
        press(1'b1);
        press(1'b0);
        press(1'b1);
        check_eq("t6_count3", COUNT, 3);
        #2 RESET = 1'b1;
        #1;
        check_eq("t6_rst_count", COUNT, 0);
        check_eq("t6_rst_valid", BIT_VALID, 0);
        tick();
        RESET = 1'b0;
        ticks(2);
        MATCH = 1'b1;
        tick();
        MATCH = 1'b0;
        ticks(2);
        check_eq("t6_locked", LOCKED, 1);
        #2 RESET = 1'b1;
        #1;
        check_eq("t6_rst_locked", LOCKED, 0);
        tick();
        RESET = 1'b0;
        ticks(2);
        MATCH = 1'b1;
        tick();
        MATCH = 1'b0;
        tick();
        check_eq("t6_locked2", LOCKED, 1);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        check_eq("t6_clear_locked", LOCKED, 0);
        check_eq("t6_clear_count", COUNT, 0);
        ticks(3);
        check_eq("t6_stay_run", LOCKED, 0);
        press(1'b0);
        check_eq("t6_run_push", COUNT, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
